// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the RV32I multi-cycle control unit:
// opcodes, FSM state encoding, ALU operation codes and mux select encodings.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_WB_MEM = 4'd4,
    S_MEM_WR = 4'd5,
    S_EXEC   = 4'd6,
    S_WB_ALU = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_FAULT  = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;

  // States in which the FSM is stalled on the memory handshake.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7 decode into the ALU operation code for
// register-register and register-immediate arithmetic.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_b5_i,
  output alu_op_t    alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (funct3_i)
      // OP-IMM has no SUBI; bit 30 there is just immediate data.
      3'b000:  alu_op_o = (opcode_i == OPC_OP && funct7_b5_i) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op_o = ALU_SLL;
      3'b010:  alu_op_o = ALU_SLT;
      3'b011:  alu_op_o = ALU_SLTU;
      3'b100:  alu_op_o = ALU_XOR;
      3'b101:  alu_op_o = funct7_b5_i ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op_o = ALU_OR;
      default: alu_op_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready with an optional timeout, and traps into a sticky fault.
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  mem_ready,
  input  logic                  zero,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic                  fault,
  output logic [3:0]            state
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  alu_op_t          dec_op, alu_op;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             timeout;
  logic             unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .opcode_i    (opcode),
    .funct3_i    (funct3),
    .funct7_b5_i (instr[30]),
    .alu_op_o    (dec_op)
  );

  // mem_ready takes priority over an expiring wait budget.
  assign timeout = (MEM_TIMEOUT != 0) && is_mem_wait(state_q) && !mem_ready &&
                   (wait_q == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_ADDR;
          OPC_OP, OPC_OPIMM:   state_d = S_EXEC;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JUMP;
          default:             state_d = S_FAULT;
        endcase
      end
      S_ADDR:   state_d = (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)    state_d = S_WB_MEM;
        else if (timeout) state_d = S_FAULT;
      end
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_FAULT;
      end
      S_EXEC:   state_d = S_WB_ALU;
      S_WB_ALU: state_d = S_FETCH;
      S_BRANCH: state_d = (funct3 == F3_BEQ || funct3 == F3_BNE) ? S_FETCH : S_FAULT;
      S_JUMP:   state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  // Counter only runs while stalled in place; any transition restarts it.
  always_comb begin
    wait_d = '0;
    if (is_mem_wait(state_q) && !mem_ready && state_d == state_q)
      wait_d = wait_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RS2;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    wb_sel    = WBSEL_ALU;
    fault     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // Held off while rst is high so a reset cycle never loads IR/PC.
        ir_write  = mem_ready && !rst;
        pc_write  = mem_ready && !rst;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: mem_read = 1'b1;
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = WBSEL_MEM;
      end
      S_MEM_WR: mem_write = 1'b1;
      S_EXEC, S_WB_ALU: begin
        alu_src_a = 1'b1;
        alu_src_b = (opcode == OPC_OP) ? SRCB_RS2 : SRCB_IMM;
        alu_op    = dec_op;
        reg_write = (state_q == S_WB_ALU);
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_SUB;
        if (funct3 == F3_BEQ)      pc_write = zero;
        else if (funct3 == F3_BNE) pc_write = !zero;
      end
      S_JUMP: begin
        alu_src_b = SRCB_IMM;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = WBSEL_PC4;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(alu_op);
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench: each instruction is expanded into an expected per-cycle
// trace (fetch, decode, phases, memory waits, faults) and compared cycle by cycle.
module tb_multicycle_control_unit;
  import rv_ctrl_pkg::*;

  localparam int TMO = 4;

  typedef struct packed {
    logic       pcw, irw, mr, mw, asa;
    logic [1:0] asb;
    logic [3:0] alu;
    logic       rw;
    logic [1:0] wbs;
    logic       flt;
    logic [3:0] st;
  } exp_t;

  typedef struct packed {
    exp_t e;
    logic rdy;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic        pc_write, ir_write, mem_read, mem_write, alu_src_a, reg_write, fault;
  logic [1:0]  alu_src_b, wb_sel;
  logic [3:0]  alu_control, state;
  exp_t        obs;
  ent_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .reg_write(reg_write), .wb_sel(wb_sel),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, ir_write, mem_read, mem_write, alu_src_a, alu_src_b,
                alu_control, reg_write, wb_sel, fault, state};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t base(input logic [3:0] st);
    exp_t e = '0;
    e.st  = st;
    e.alu = ALU_ADD;
    return e;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] ins);
    logic [3:0] tab [8];
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (ins[14:12] == 3'd0 && ins[6:0] == OPC_OP && ins[30]) return ALU_SUB;
    if (ins[14:12] == 3'd5 && ins[30]) return ALU_SRA;
    return tab[ins[14:12]];
  endfunction

  task automatic push(input exp_t e, input logic r);
    ent_t x;
    x.e   = e;
    x.rdy = r;
    q.push_back(x);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_fault();
    exp_t e;
    e = base(S_FAULT);
    e.flt = 1'b1;
    for (int i = 0; i < 3; i++) push(e, rnd_bit());
  endtask

  // kind: 0 = instruction fetch, 1 = data read, 2 = data write
  task automatic mem_phase(input int w, input int kind, output bit ok);
    exp_t e;
    e = base(kind == 0 ? S_FETCH : (kind == 1 ? S_MEM_RD : S_MEM_WR));
    e.mr  = (kind != 2);
    e.mw  = (kind == 2);
    e.asb = (kind == 0) ? SRCB_FOUR : SRCB_RS2;
    ok = (w <= TMO);
    for (int i = 0; i < (ok ? w : TMO + 1); i++) push(e, 1'b0);
    if (ok) begin
      e.irw = (kind == 0);
      e.pcw = (kind == 0);
      push(e, 1'b1);
    end else begin
      push_fault();
    end
  endtask

  task automatic build(input logic [31:0] ins, input int fw, input int mw,
                       input logic z, output bit flt);
    exp_t e;
    bit   ok;
    q.delete();
    flt = 1'b0;
    mem_phase(fw, 0, ok);
    if (!ok) begin
      flt = 1'b1;
      return;
    end
    push(base(S_DECODE), rnd_bit());
    case (ins[6:0])
      OPC_LOAD, OPC_STORE: begin
        e = base(S_ADDR);
        e.asa = 1'b1;
        e.asb = SRCB_IMM;
        push(e, rnd_bit());
        if (ins[6:0] == OPC_LOAD) begin
          mem_phase(mw, 1, ok);
          if (ok) begin
            e = base(S_WB_MEM);
            e.rw  = 1'b1;
            e.wbs = WBSEL_MEM;
            push(e, rnd_bit());
          end
        end else begin
          mem_phase(mw, 2, ok);
        end
        flt = !ok;
      end
      OPC_OP, OPC_OPIMM: begin
        e = base(S_EXEC);
        e.asa = 1'b1;
        e.asb = (ins[6:0] == OPC_OP) ? SRCB_RS2 : SRCB_IMM;
        e.alu = ref_alu(ins);
        push(e, rnd_bit());
        e.st  = S_WB_ALU;
        e.rw  = 1'b1;
        e.wbs = WBSEL_ALU;
        push(e, rnd_bit());
      end
      OPC_BRANCH: begin
        e = base(S_BRANCH);
        e.asa = 1'b1;
        e.asb = SRCB_RS2;
        e.alu = ALU_SUB;
        if (ins[14:12] == 3'd0)      e.pcw = z;
        else if (ins[14:12] == 3'd1) e.pcw = !z;
        push(e, rnd_bit());
        if (ins[14:12] > 3'd1) begin
          push_fault();
          flt = 1'b1;
        end
      end
      OPC_JAL: begin
        e = base(S_JUMP);
        e.asb = SRCB_IMM;
        e.pcw = 1'b1;
        e.rw  = 1'b1;
        e.wbs = WBSEL_PC4;
        push(e, rnd_bit());
      end
      default: begin
        push_fault();
        flt = 1'b1;
      end
    endcase
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < q.size() && i < n; i++) begin
      mem_ready = q[i].rdy;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), 32'(obs), 32'(q[i].e));
      @(posedge clk); #1;
    end
  endtask

  // Reset cycle shows FETCH defaults with IR/PC loads suppressed even with mem_ready high.
  task automatic do_reset();
    exp_t e;
    e = base(S_FETCH);
    e.mr  = 1'b1;
    e.asb = SRCB_FOUR;
    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset", 32'(obs), 32'(e));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_instr(input logic [31:0] ins, input int fw, input int mw,
                          input logic z, input string tag);
    bit flt;
    instr = ins;
    zero  = z;
    build(ins, fw, mw, z, flt);
    run(q.size(), tag);
    if (flt) do_reset();
  endtask

  function automatic int rnd_wait();
    return ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 6);
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] ins;
    logic [6:0]  o;
    ins = $urandom;
    case ($urandom_range(0, 6))
      0: ins[6:0] = OPC_OP;
      1: ins[6:0] = OPC_OPIMM;
      2: ins[6:0] = OPC_LOAD;
      3: ins[6:0] = OPC_STORE;
      4: begin
        ins[6:0] = OPC_BRANCH;
        if ($urandom_range(0, 3) != 0) ins[14:12] = 3'($urandom_range(0, 1));
      end
      5: ins[6:0] = OPC_JAL;
      default: begin
        do o = 7'($urandom);
        while (o inside {OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH, OPC_JAL});
        ins[6:0] = o;
      end
    endcase
    return ins;
  endfunction

  initial begin
    bit flt;
    @(posedge clk); #1;
    do_reset();

    do_instr(32'h002081B3, 0, 0, 1'b0, "add");
    do_instr(32'h0000A283, 0, 3, 1'b0, "lw_wait3");
    do_instr(32'h0050A023, 1, 2, 1'b0, "sw");
    do_instr(32'h00208063, 0, 0, 1'b1, "beq_z1");
    do_instr(32'h00209063, 0, 0, 1'b1, "bne_z1");
    do_instr(32'h00209063, 0, 0, 1'b0, "bne_z0");
    do_instr(32'h0020C063, 0, 0, 1'b0, "br_f3_100");
    do_instr(32'h40315093, 0, 0, 1'b0, "srai");
    do_instr(32'h402081B3, 0, 0, 1'b0, "sub");
    do_instr(32'h40008093, 0, 0, 1'b0, "addi_imm10");
    do_instr(32'h008000EF, 0, 0, 1'b0, "jal");
    do_instr(32'h002081B3, TMO, 0, 1'b0, "fetch_ready_at_limit");
    do_instr(32'h0000A283, 0, TMO, 1'b0, "rd_ready_at_limit");
    do_instr(32'h002081B3, TMO + 1, 0, 1'b0, "fetch_timeout");
    do_instr(32'h0000007F, 0, 0, 1'b0, "illegal");

    // Reset while stalled in the store data phase.
    instr = 32'h0050A023;
    zero  = 1'b0;
    build(instr, 0, 10, 1'b0, flt);
    run(5, "sw_wait");
    do_reset();

    for (int n = 0; n < 200; n++)
      do_instr(rnd_instr(), rnd_wait(), rnd_wait(), rnd_bit(), $sformatf("rnd%0d", n));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
